seq2_core: RTL and testbench
============================

// Module: seq2_core
// PURPOSE
// - Instruction sequencer: executes one 20-bit instruction per clock from an external controller.
// - Drives the next-instruction address and writes 12-bit commands to one of 8 output registers.
// - Sits between a program memory/controller and 8 downstream command sinks.
// - Four 8-bit input registers supply run-time data for conditional jumps and waits.
// PARAMETERS
// - none (all widths fixed: inst 20, address 8, oreg 12, 8 oregs, 4 iregs)
// PORTS
// clock     in   1   single clock; all state updates on rising edge
// reset     in   1   synchronous, active-low reset
// inst      in   20  instruction {opcode[19:16], operands[15:0]}
// inst_en   in   1   inst valid this cycle; when low, no instruction executes
// ireg_0..3 in   8   input data registers (four separate ports)
// next      out  8   address of next instruction (registered)
// oreg      out  12  command word for output registers (registered)
// oreg_wen  out  8   one-hot write enable selecting oreg target (registered, 1-cycle pulse)
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low.
// - States: RESET, READY, ERROR. Reset low at an edge -> RESET, next=0, oreg=0, oreg_wen=0.
// - RESET -> READY at first edge with reset high; no instruction executes in RESET.
// - READY, inst_en=0: hold next/oreg, oreg_wen=0.
// - READY, inst_en=1: decode opcode; results visible after that edge (1-cycle latency).
// - oreg_wen defaults to 0 every cycle except the cycle after CI/CR.
// - oreg holds its last written value.
// - Opcodes (4-bit):
//   - NO=0: next<=next+1.
//   - CI=1 {op,x,sel[2:0],hi[3:0],imm[7:0]}: oreg<={hi,imm}; oreg_wen<=1<<sel; next+1.
//   - CR=2 {op,x,sel[2:0],hi[3:0],6'bx,r[1:0]}: oreg<={hi,ireg_r}; oreg_wen<=1<<sel; next+1.
//   - JI=3 {op,addr[7:0],8'bx}: next<=addr.
//   - JR=4 {op,14'bx,r[1:0]}: next<=ireg_r.
//   - JZ=5 {op,addr[7:0],6'bx,r[1:0]}: next<=addr if ireg_r==0, else next+1.
//   - WN=6 {op,14'bx,r[1:0]}: if ireg_r!=0 next<=next+1, else hold next (controller re-presents WN).
//   - WN is evaluated only on edges with inst_en=1; a value turning non-zero while inst_en=0 has no effect until inst_en returns.
//   - Any other opcode (7..15) -> ERROR.
// - ERROR: all instructions ignored; next held; oreg_wen=0; exit only via reset.
// - next increments modulo 256 (0xFF -> 0x00).
// - Reset has priority over everything, including mid-WN and ERROR.
// - Operand fields marked x are don't-care; unknown values there must not affect outputs.
// STRUCTURE
// - Shared package seq2_pkg: opcode localparams (NO..WN), state enum {RESET,READY,ERROR}, field positions.
// - Single module; optional combinational sub-module seq2_ireg_mux (2-bit select of ireg_0..3).
// TESTING
// - Reset, then NO -> next 0->1; oreg=0, oreg_wen=0.
// - CI sel=1,hi=2,imm=AA -> oreg=0x2AA, oreg_wen=0x02 for one cycle.
// - CR sel=2,hi=3,r=1, ireg_1=AA -> oreg=0x3AA, oreg_wen=0x04.
// - JI A0 -> next=A0; JR r=2, ireg_2=BA -> next=BA.
// - JZ E0 r=3 ireg_3=0 -> next=E0; JZ F0 r=0 ireg_0=10 -> next+1.
// - WN r=1, ireg_1=0 for 5 cycles -> next held; ireg_1=1 -> next+1.
// - WN with inst_en dropped: ireg_1 -> 1 while inst_en=0 -> next held until inst_en=1.
// - Opcode F -> ERROR; subsequent JI BB ignored; reset pulse, then JI BB -> next=BB.

Source files
------------

// File: rtl/seq2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq2_pkg
//  Brief    : Shared opcodes, state encoding and instruction field positions
//             for the seq2 instruction sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package seq2_pkg;

    localparam logic [3:0] c_op_no = 4'd0;
    localparam logic [3:0] c_op_ci = 4'd1;
    localparam logic [3:0] c_op_cr = 4'd2;
    localparam logic [3:0] c_op_ji = 4'd3;
    localparam logic [3:0] c_op_jr = 4'd4;
    localparam logic [3:0] c_op_jz = 4'd5;
    localparam logic [3:0] c_op_wn = 4'd6;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_ERROR = 2'd2
    } seq2_state_t;

    // Instruction field positions (msb/lsb)
    localparam int c_op_msb   = 19;
    localparam int c_op_lsb   = 16;
    localparam int c_addr_msb = 15;
    localparam int c_addr_lsb = 8;
    localparam int c_sel_msb  = 14;
    localparam int c_sel_lsb  = 12;
    localparam int c_hi_msb   = 11;
    localparam int c_hi_lsb   = 8;
    localparam int c_imm_msb  = 7;
    localparam int c_imm_lsb  = 0;
    localparam int c_reg_msb  = 1;
    localparam int c_reg_lsb  = 0;

    function automatic logic [7:0] sel_onehot(input logic [2:0] sel);
        return 8'd1 << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq2_ireg_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seq2_ireg_mux
//  Brief    : Combinational 4:1 selector over the four 8-bit input registers.
//  Revision : 1.0  initial release
// ============================================================================
module seq2_ireg_mux (
    input  logic [1:0] i_sel,
    input  logic [7:0] i_ireg_0,
    input  logic [7:0] i_ireg_1,
    input  logic [7:0] i_ireg_2,
    input  logic [7:0] i_ireg_3,
    output logic [7:0] o_data
);

    always_comb begin
        o_data = i_ireg_0;
        case (i_sel)
            2'd0:    o_data = i_ireg_0;
            2'd1:    o_data = i_ireg_1;
            2'd2:    o_data = i_ireg_2;
            default: o_data = i_ireg_3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq2_core.sv
`default_nettype none
// ============================================================================
//  Module   : seq2_core
//  Brief    : One-instruction-per-clock sequencer driving the next-address
//             pointer and one-hot-addressed 12-bit command writes.
//  Revision : 1.0  initial release
// ============================================================================
module seq2_core
    import seq2_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] inst,
    input  logic        inst_en,
    input  logic [7:0]  ireg_0,
    input  logic [7:0]  ireg_1,
    input  logic [7:0]  ireg_2,
    input  logic [7:0]  ireg_3,
    output logic [7:0]  next,
    output logic [11:0] oreg,
    output logic [7:0]  oreg_wen
);

    seq2_state_t r_state;
    seq2_state_t w_state_nxt;

    logic [7:0]  r_next;
    logic [11:0] r_oreg;
    logic [7:0]  r_oreg_wen;

    logic [7:0]  w_next_nxt;
    logic [11:0] w_oreg_nxt;
    logic [7:0]  w_oreg_wen_nxt;

    logic [3:0]  w_opcode;
    logic [7:0]  w_addr;
    logic [2:0]  w_sel;
    logic [3:0]  w_hi;
    logic [7:0]  w_imm;
    logic [1:0]  w_reg;
    logic [7:0]  w_ireg_val;
    logic [7:0]  w_next_inc;

    assign w_opcode   = inst[c_op_msb:c_op_lsb];
    assign w_addr     = inst[c_addr_msb:c_addr_lsb];
    assign w_sel      = inst[c_sel_msb:c_sel_lsb];
    assign w_hi       = inst[c_hi_msb:c_hi_lsb];
    assign w_imm      = inst[c_imm_msb:c_imm_lsb];
    assign w_reg      = inst[c_reg_msb:c_reg_lsb];
    assign w_next_inc = r_next + 8'd1;

    seq2_ireg_mux u_ireg_mux (
        .i_sel    (w_reg),
        .i_ireg_0 (ireg_0),
        .i_ireg_1 (ireg_1),
        .i_ireg_2 (ireg_2),
        .i_ireg_3 (ireg_3),
        .o_data   (w_ireg_val)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_RESET;
            r_next     <= 8'd0;
            r_oreg     <= 12'd0;
            r_oreg_wen <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_next     <= w_next_nxt;
            r_oreg     <= w_oreg_nxt;
            r_oreg_wen <= w_oreg_wen_nxt;
        end
    end

    // Only the decoded opcode's own fields are consulted, so don't-care
    // operand bits never reach the outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_next_nxt     = r_next;
        w_oreg_nxt     = r_oreg;
        w_oreg_wen_nxt = 8'd0;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_READY;
            end
            ST_READY: begin
                if (inst_en) begin
                    case (w_opcode)
                        c_op_no: begin
                            w_next_nxt = w_next_inc;
                        end
                        c_op_ci: begin
                            w_oreg_nxt     = {w_hi, w_imm};
                            w_oreg_wen_nxt = sel_onehot(w_sel);
                            w_next_nxt     = w_next_inc;
                        end
                        c_op_cr: begin
                            w_oreg_nxt     = {w_hi, w_ireg_val};
                            w_oreg_wen_nxt = sel_onehot(w_sel);
                            w_next_nxt     = w_next_inc;
                        end
                        c_op_ji: begin
                            w_next_nxt = w_addr;
                        end
                        c_op_jr: begin
                            w_next_nxt = w_ireg_val;
                        end
                        c_op_jz: begin
                            w_next_nxt = (w_ireg_val == 8'd0) ? w_addr : w_next_inc;
                        end
                        c_op_wn: begin
                            // Controller re-presents WN until the register goes non-zero
                            if (w_ireg_val != 8'd0) begin
                                w_next_nxt = w_next_inc;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_ERROR;
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = ST_ERROR;
            end
        endcase
    end

    assign next     = r_next;
    assign oreg     = r_oreg;
    assign oreg_wen = r_oreg_wen;

endmodule
`default_nettype wire

// File: tb/tb_seq2_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq2_core
//  Brief    : Self-checking bench for seq2_core with directed and random
//             instruction streams against an abstract reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq2_core;

    logic        clock;
    logic        reset;
    logic [19:0] inst;
    logic        inst_en;
    logic [7:0]  ireg_0;
    logic [7:0]  ireg_1;
    logic [7:0]  ireg_2;
    logic [7:0]  ireg_3;
    logic [7:0]  next;
    logic [11:0] oreg;
    logic [7:0]  oreg_wen;

    int n_vec;
    int n_err;

    localparam int c_m_rst = 0;
    localparam int c_m_rdy = 1;
    localparam int c_m_err = 2;

    int m_state;
    int m_next;
    int m_oreg;
    int m_wen;

    seq2_core dut (
        .clock    (clock),
        .reset    (reset),
        .inst     (inst),
        .inst_en  (inst_en),
        .ireg_0   (ireg_0),
        .ireg_1   (ireg_1),
        .ireg_2   (ireg_2),
        .ireg_3   (ireg_3),
        .next     (next),
        .oreg     (oreg),
        .oreg_wen (oreg_wen)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ireg_pick(input logic [1:0] r);
        case (r)
            2'd0:    return int'(ireg_0);
            2'd1:    return int'(ireg_1);
            2'd2:    return int'(ireg_2);
            default: return int'(ireg_3);
        endcase
    endfunction

    // Reference behaviour for one rising edge, from the instruction rules
    task automatic model_edge();
        int op;
        int rv;
        if (!reset) begin
            m_state = c_m_rst;
            m_next  = 0;
            m_oreg  = 0;
            m_wen   = 0;
        end else begin
            m_wen = 0;
            if (m_state == c_m_rst) begin
                m_state = c_m_rdy;
            end else if (m_state == c_m_rdy && inst_en) begin
                op = int'(inst[19:16]);
                rv = ireg_pick(inst[1:0]);
                case (op)
                    0: m_next = (m_next + 1) % 256;
                    1: begin
                        m_oreg = int'(inst[11:8]) * 256 + int'(inst[7:0]);
                        m_wen  = 2 ** int'(inst[14:12]);
                        m_next = (m_next + 1) % 256;
                    end
                    2: begin
                        m_oreg = int'(inst[11:8]) * 256 + rv;
                        m_wen  = 2 ** int'(inst[14:12]);
                        m_next = (m_next + 1) % 256;
                    end
                    3: m_next = int'(inst[15:8]);
                    4: m_next = rv;
                    5: m_next = (rv == 0) ? int'(inst[15:8]) : (m_next + 1) % 256;
                    6: if (rv != 0) m_next = (m_next + 1) % 256;
                    default: m_state = c_m_err;
                endcase
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic [19:0] ins, input logic en, input string tag);
        reset   = rst_n;
        inst    = ins;
        inst_en = en;
        @(posedge clock);
        model_edge();
        #1;
        check({tag, ".next"}, 32'(next), 32'(m_next));
        check({tag, ".oreg"}, 32'(oreg), 32'(m_oreg));
        check({tag, ".wen"},  32'(oreg_wen), 32'(m_wen));
    endtask

    // Instruction builders; don't-care fields are filled with random bits
    function automatic logic [19:0] f_no();
        logic [15:0] x = 16'($urandom);
        return {4'd0, x};
    endfunction
    function automatic logic [19:0] f_ci(input logic [2:0] sel, input logic [3:0] hi, input logic [7:0] imm);
        logic x = 1'($urandom);
        return {4'd1, x, sel, hi, imm};
    endfunction
    function automatic logic [19:0] f_cr(input logic [2:0] sel, input logic [3:0] hi, input logic [1:0] r);
        logic       x = 1'($urandom);
        logic [5:0] y = 6'($urandom);
        return {4'd2, x, sel, hi, y, r};
    endfunction
    function automatic logic [19:0] f_ji(input logic [7:0] addr);
        logic [7:0] x = 8'($urandom);
        return {4'd3, addr, x};
    endfunction
    function automatic logic [19:0] f_jr(input logic [1:0] r);
        logic [13:0] x = 14'($urandom);
        return {4'd4, x, r};
    endfunction
    function automatic logic [19:0] f_jz(input logic [7:0] addr, input logic [1:0] r);
        logic [5:0] x = 6'($urandom);
        return {4'd5, addr, x, r};
    endfunction
    function automatic logic [19:0] f_wn(input logic [1:0] r);
        logic [13:0] x = 14'($urandom);
        return {4'd6, x, r};
    endfunction

    initial begin
        int pick;
        n_vec   = 0;
        n_err   = 0;
        m_state = c_m_rst;
        m_next  = 0;
        m_oreg  = 0;
        m_wen   = 0;
        reset   = 1'b0;
        inst    = '0;
        inst_en = 1'b0;
        ireg_0  = 8'h10;
        ireg_1  = 8'hAA;
        ireg_2  = 8'hBA;
        ireg_3  = 8'h00;

        step(1'b0, f_no(), 1'b1, "reset0");
        step(1'b0, f_no(), 1'b1, "reset1");
        step(1'b1, f_no(), 1'b1, "leave_reset");
        step(1'b1, f_no(), 1'b1, "no");
        step(1'b1, f_ci(3'd1, 4'h2, 8'hAA), 1'b1, "ci");
        step(1'b1, f_no(), 1'b0, "ci_pulse_end");
        step(1'b1, f_cr(3'd2, 4'h3, 2'd1), 1'b1, "cr");
        step(1'b1, f_ji(8'hA0), 1'b1, "ji");
        step(1'b1, f_jr(2'd2), 1'b1, "jr");
        step(1'b1, f_jz(8'hE0, 2'd3), 1'b1, "jz_taken");
        step(1'b1, f_jz(8'hF0, 2'd0), 1'b1, "jz_not_taken");
        step(1'b1, f_ji(8'hFF), 1'b1, "ji_ff");
        step(1'b1, f_no(), 1'b1, "wrap");

        ireg_1 = 8'h00;
        for (int i = 0; i < 5; i++) step(1'b1, f_wn(2'd1), 1'b1, "wn_hold");
        ireg_1 = 8'h01;
        step(1'b1, f_wn(2'd1), 1'b1, "wn_go");

        ireg_1 = 8'h00;
        step(1'b1, f_wn(2'd1), 1'b1, "wn2_hold");
        ireg_1 = 8'h01;
        step(1'b1, f_wn(2'd1), 1'b0, "wn2_en_low");
        step(1'b1, f_wn(2'd1), 1'b0, "wn2_en_low2");
        step(1'b1, f_wn(2'd1), 1'b1, "wn2_go");

        step(1'b1, {4'hF, 16'($urandom)}, 1'b1, "illegal");
        step(1'b1, f_ji(8'hBB), 1'b1, "err_ji_ignored");
        step(1'b1, f_ci(3'd5, 4'h1, 8'h23), 1'b1, "err_ci_ignored");
        step(1'b0, f_ji(8'hBB), 1'b1, "err_reset");
        step(1'b1, f_ji(8'hBB), 1'b1, "post_reset_state");
        step(1'b1, f_ji(8'hBB), 1'b1, "post_reset_ji");

        for (int i = 0; i < 600; i++) begin
            ireg_0 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            ireg_1 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            ireg_2 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            ireg_3 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            pick   = $urandom_range(0, 99);
            if (pick < 3) begin
                step(1'b0, f_no(), 1'($urandom), "rnd_reset");
            end else if (pick < 5) begin
                step(1'b1, {4'($urandom_range(7, 15)), 16'($urandom)}, 1'b1, "rnd_illegal");
            end else begin
                case ($urandom_range(0, 6))
                    0: step(1'b1, f_no(), 1'($urandom_range(0, 3) != 0), "rnd_no");
                    1: step(1'b1, f_ci(3'($urandom), 4'($urandom), 8'($urandom)),
                            1'($urandom_range(0, 3) != 0), "rnd_ci");
                    2: step(1'b1, f_cr(3'($urandom), 4'($urandom), 2'($urandom)),
                            1'($urandom_range(0, 3) != 0), "rnd_cr");
                    3: step(1'b1, f_ji(8'($urandom)), 1'($urandom_range(0, 3) != 0), "rnd_ji");
                    4: step(1'b1, f_jr(2'($urandom)), 1'($urandom_range(0, 3) != 0), "rnd_jr");
                    5: step(1'b1, f_jz(8'($urandom), 2'($urandom)),
                            1'($urandom_range(0, 3) != 0), "rnd_jz");
                    default: step(1'b1, f_wn(2'($urandom)), 1'($urandom_range(0, 3) != 0), "rnd_wn");
                endcase
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
